// File: rtl/priv_trap_ctrl.sv
// Trap sequencer: prioritises exceptions over machine interrupts over mret, waits for
// the pipeline flush, then issues the CSR write pulse and the PC redirect in one cycle.
`ifndef NUM_EXTENSIONS
`define NUM_EXTENSIONS 4
`endif

module priv_trap_ctrl #(
    parameter int RESOURCE_CAUSE_BASE = 24,
    parameter int NUM_EXT             = `NUM_EXTENSIONS,
    localparam int CW                 = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          pipe_clear,
    input  logic          ret,
    input  logic          fault_insn,
    input  logic          mal_insn,
    input  logic          illegal_insn,
    input  logic          fault_l,
    input  logic          mal_l,
    input  logic          fault_s,
    input  logic          mal_s,
    input  logic          breakpoint,
    input  logic          env_m,
    input  logic          ex_rmgmt,
    input  logic [CW-1:0] ex_rmgmt_cause,
    input  logic [31:0]   epc,
    input  logic [31:0]   badaddr,
    input  logic          mei_pend,
    input  logic          msi_pend,
    input  logic          mti_pend,
    input  logic          mstatus_mie,
    input  logic [31:0]   mtvec,
    input  logic [31:0]   mepc_q,
    output logic          intr,
    output logic          insert_pc,
    output logic [31:0]   priv_pc,
    output logic [31:0]   mcause_wdata,
    output logic [31:0]   mepc_wdata,
    output logic [31:0]   mtval_wdata,
    output logic          trap_we,
    output logic          mret_we
);

    typedef enum logic [1:0] {IDLE, TRAP_WAIT, RET_WAIT, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, epc_q, tval_q, pc_q;
    logic        is_ret_q;

    logic        exc_hit, exc_tval, irq_hit;
    logic [30:0] exc_code, irq_code;
    logic [31:0] trap_base, trap_target;

    // Synchronous exception priority; only fault/misaligned causes carry a tval.
    always_comb begin
        exc_hit  = 1'b1;
        exc_tval = 1'b0;
        exc_code = '0;
        if (breakpoint)        exc_code = 31'd3;
        else if (fault_insn)   begin exc_code = 31'd1;  exc_tval = 1'b1; end
        else if (mal_insn)     begin exc_code = 31'd0;  exc_tval = 1'b1; end
        else if (illegal_insn) exc_code = 31'd2;
        else if (env_m)        exc_code = 31'd11;
        else if (mal_l)        begin exc_code = 31'd4;  exc_tval = 1'b1; end
        else if (mal_s)        begin exc_code = 31'd6;  exc_tval = 1'b1; end
        else if (fault_l)      begin exc_code = 31'd5;  exc_tval = 1'b1; end
        else if (fault_s)      begin exc_code = 31'd7;  exc_tval = 1'b1; end
        else if (ex_rmgmt)     exc_code = 31'(RESOURCE_CAUSE_BASE) + 31'(ex_rmgmt_cause);
        else                   exc_hit  = 1'b0;
    end

    always_comb begin
        irq_hit  = mstatus_mie & (mei_pend | msi_pend | mti_pend);
        irq_code = mei_pend ? 31'd11 : (msi_pend ? 31'd3 : 31'd7);
    end

    always_comb begin
        trap_base   = {mtvec[31:2], 2'b00};
        trap_target = trap_base;
        if (cause_q[31] && mtvec[1:0] == 2'd1)
            trap_target = trap_base + {cause_q[29:0], 2'b00};
    end

    always_comb begin
        state_d   = state_q;
        intr      = 1'b0;
        insert_pc = 1'b0;
        trap_we   = 1'b0;
        mret_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_hit || irq_hit) state_d = TRAP_WAIT;
                else if (ret)           state_d = RET_WAIT;
            end
            TRAP_WAIT: begin
                intr = 1'b1;
                if (pipe_clear) state_d = COMMIT;
            end
            RET_WAIT: begin
                if (pipe_clear) state_d = COMMIT;
            end
            COMMIT: begin
                insert_pc = 1'b1;
                trap_we   = ~is_ret_q;
                mret_we   = is_ret_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            pc_q     <= '0;
            is_ret_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (exc_hit) begin
                    cause_q  <= {1'b0, exc_code};
                    epc_q    <= epc;
                    tval_q   <= exc_tval ? badaddr : 32'd0;
                    is_ret_q <= 1'b0;
                end else if (irq_hit) begin
                    cause_q  <= {1'b1, irq_code};
                    epc_q    <= epc;
                    tval_q   <= 32'd0;
                    is_ret_q <= 1'b0;
                end else if (ret) begin
                    is_ret_q <= 1'b1;
                end
            end
            // Redirect target is captured on the edge into COMMIT and then held.
            if (state_q != COMMIT && state_d == COMMIT)
                pc_q <= is_ret_q ? mepc_q : trap_target;
        end
    end

    assign priv_pc      = pc_q;
    assign mcause_wdata = cause_q;
    assign mepc_wdata   = epc_q;
    assign mtval_wdata  = tval_q;

endmodule

// File: doc/priv_trap_ctrl.md
Name: priv_trap_ctrl

Overview:
Trap sequencer inside the priv block. It consumes the exception, return and flush signals driven by the hazard unit, prioritises them against pending machine interrupts, and latches the trap cause, EPC and fault address. It then waits for the pipeline flush to complete, commits the machine-mode CSR updates as one-cycle write pulses, and produces the insert_pc/priv_pc redirect that the hazard unit consumes.

Parameters:
RESOURCE_CAUSE_BASE, 24, mcause code for the resource-management exception = base + ex_rmgmt_cause.
NUM_EXT, `NUM_EXTENSIONS, number of resource-management extensions; sizes ex_rmgmt_cause.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
pipe_clear  in  1  pipeline has drained; held high until redirect is taken
ret  in  1  mret retiring
fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m  in  1 each  synchronous exception flags
ex_rmgmt  in  1  resource-management exception
ex_rmgmt_cause  in  $clog2(NUM_EXT)  extension index
epc  in  32  PC of the faulting or next instruction
badaddr  in  32  faulting address
mei_pend, msi_pend, mti_pend  in  1 each  mip bits ANDed with mie
mstatus_mie  in  1  global interrupt enable
mtvec  in  32  [31:2] base, [1:0] mode (0 direct, 1 vectored)
mepc_q  in  32  current mepc (return target)
intr  out  1  trap pending; hazard unit must flush
insert_pc  out  1  one-cycle redirect strobe
priv_pc  out  32  redirect target, valid while insert_pc is high
mcause_wdata  out  32  [31] interrupt, [30:0] code
mepc_wdata, mtval_wdata  out  32 each
trap_we  out  1  one-cycle pulse: write mcause/mepc/mtval; set MPIE=MIE, MIE=0
mret_we  out  1  one-cycle pulse: set MIE=MPIE, MPIE=1

Behaviour:
- FSM states: IDLE, TRAP_WAIT, RET_WAIT, COMMIT. On reset: IDLE; all outputs 0; latched cause/epc/tval registers 0.
- IDLE, evaluated every cycle:
  - If any exception flag is high, latch the highest-priority one. Priority high to low, with mcause code: breakpoint 3, fault_insn 1, mal_insn 0, illegal_insn 2, env_m 11, mal_l 4, mal_s 6, fault_l 5, fault_s 7, ex_rmgmt RESOURCE_CAUSE_BASE+ex_rmgmt_cause. Set mcause[31]=0 and latch epc. Latch mtval=badaddr for fault/mal causes; mtval=0 for all other causes. Go to TRAP_WAIT.
  - Else if mstatus_mie and any *_pend: take the interrupt. Priority mei 11 > msi 3 > mti 7. Set mcause[31]=1, latch mtval=0 and epc. Go to TRAP_WAIT.
  - Else if ret: go to RET_WAIT.
  - Exception beats interrupt beats ret on the same cycle. Extra causes in the same cycle are dropped.
- TRAP_WAIT:
  - intr=1. Inputs other than pipe_clear and RST are ignored; the latched trap stands even if its source deasserts.
  - When pipe_clear=1, go to COMMIT in the next cycle.
  - A pipe_clear that is already high on entry counts, so the minimum latency from exception to insert_pc is 2 cycles.
- RET_WAIT: intr=0. When pipe_clear=1, go to COMMIT with the ret flag set.
- COMMIT (exactly one cycle, then IDLE):
  - Assert insert_pc=1.
  - Trap:
    - trap_we=1; mcause/mepc/mtval_wdata hold the latched values.
    - priv_pc = {mtvec[31:2],2'b00}, or that base + 4*code for an interrupt when mtvec[1:0]==1.
    - Modes 2 and 3 are treated as direct.
  - Ret: mret_we=1, priv_pc = mepc_q.
  - intr drops in COMMIT.
- Data outputs (priv_pc and the *_wdata) hold their values outside COMMIT. Consumers may only sample them while insert_pc, trap_we or mret_we is high.
- A new exception in the COMMIT cycle is ignored; the hazard unit re-presents it after the redirect.
- Arithmetic: the vector add is 32-bit and wraps with no overflow detection. The cause code is zero-extended into mcause[30:0].
- RST high in any state: next cycle is IDLE, outputs are 0, and pending latches are cleared. No CSR pulse is issued for an aborted trap.

Test Plan:
- Illegal instruction: illegal_insn=1, epc=0x200, mtvec=0x1000; pipe_clear high 3 cycles later -> intr high 1 cycle after the flag. COMMIT gives trap_we=1, mcause=0x2, mepc=0x200, mtval=0, insert_pc=1, priv_pc=0x1000.
- Priority and interrupt: mal_l + fault_s together with mti_pend and mie=1; badaddr=0x33 -> mcause=4, mtval=0x33. Repeat with no exceptions and mtvec=0x1001 -> mcause=0x80000007, priv_pc=0x101C.
- Interrupt masking: mti_pend=1, mstatus_mie=0 -> state stays IDLE and intr stays 0 for 20 cycles.
- mret: ret=1, mepc_q=0x4004; pipe_clear held high -> insert_pc and mret_we pulse together 2 cycles later, priv_pc=0x4004, trap_we=0.
- Simultaneous causes: ret + env_m same cycle -> trap taken with mcause=11, mret_we never pulses. ex_rmgmt with cause 1 -> mcause=25.
- Reset mid-operation: RST asserted while in TRAP_WAIT, then pipe_clear -> no trap_we or insert_pc; all outputs 0 the cycle after RST.
